// File: rtl/aes_128_sched.sv
// rtl/aes_128_sched.sv - two-requester round-robin scheduler for a fixed-latency aes_128 core
module aes_128_sched #(
    parameter int LAT   = 21,
    parameter int DEPTH = 4,
    parameter int TAGW  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [255:0]        req_state,
    input  logic [255:0]        req_key,
    input  logic [2*TAGW-1:0]   req_tag,
    output logic [127:0]        core_state,
    output logic [127:0]        core_key,
    input  logic [127:0]        core_out,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [127:0]        rsp_data,
    output logic                rsp_id,
    output logic [TAGW-1:0]     rsp_tag,
    output logic                busy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = 128 + 1 + TAGW;

    logic [CW-1:0]   inflight;
    logic [CW-1:0]   fifo_count;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            last_id;
    logic [1:0]      grant;
    logic            credit;
    logic            issue;
    logic            issue_id;
    logic [TAGW-1:0] issue_tag;
    logic            emerge;
    logic            pop;
    logic [LAT:1]    trk_valid;
    logic [LAT:1]    trk_id;
    logic [TAGW-1:0] trk_tag [1:LAT];
    logic [EW-1:0]   mem [DEPTH];

    // Credit counts both in-flight work and buffered results, so every emerging result has a slot.
    always_comb begin
        grant = req_valid;
        if (req_valid == 2'b11) begin
            grant = last_id ? 2'b01 : 2'b10;
        end
        credit    = rst_n && (({1'b0, inflight} + {1'b0, fifo_count}) < (CW + 1)'(DEPTH));
        req_ready = credit ? grant : 2'b00;
        issue     = |(req_valid & req_ready);
        issue_id  = req_ready[1];
        issue_tag = issue_id ? req_tag[2*TAGW-1:TAGW] : req_tag[TAGW-1:0];
        core_state = '0;
        core_key   = '0;
        if (issue) begin
            core_state = issue_id ? req_state[255:128] : req_state[127:0];
            core_key   = issue_id ? req_key[255:128]   : req_key[127:0];
        end
    end

    assign emerge    = trk_valid[LAT];
    assign rsp_valid = (fifo_count != '0);
    assign pop       = rsp_valid & rsp_ready;
    assign {rsp_data, rsp_id, rsp_tag} = mem[rd_ptr];
    assign busy      = (inflight != '0) || (fifo_count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trk_valid <= '0;
            trk_id    <= '0;
            for (int i = 1; i <= LAT; i++) begin
                trk_tag[i] <= '0;
            end
        end else begin
            trk_valid <= {trk_valid[LAT-1:1], issue};
            trk_id    <= {trk_id[LAT-1:1], issue_id};
            trk_tag[1] <= issue_tag;
            for (int i = 2; i <= LAT; i++) begin
                trk_tag[i] <= trk_tag[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight   <= '0;
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            last_id    <= 1'b1;
        end else begin
            if (issue && !emerge) begin
                inflight <= inflight + CW'(1);
            end else if (!issue && emerge) begin
                inflight <= inflight - CW'(1);
            end
            if (emerge && !pop) begin
                fifo_count <= fifo_count + CW'(1);
            end else if (!emerge && pop) begin
                fifo_count <= fifo_count - CW'(1);
            end
            if (emerge) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (issue) begin
                last_id <= issue_id;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (emerge) begin
            mem[wr_ptr] <= {core_out, trk_id[LAT], trk_tag[LAT]};
        end
    end
endmodule

// File: tb/tb_aes_128_sched.sv
// tb/tb_aes_128_sched.sv - directed self-checking bench for aes_128_sched
module tb_aes_128_sched;
    localparam int LAT   = 21;
    localparam int DEPTH = 4;
    localparam int TAGW  = 4;

    localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic               clk;
    logic               rst_n;
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [255:0]       req_state;
    logic [255:0]       req_key;
    logic [2*TAGW-1:0]  req_tag;
    logic [127:0]       core_state;
    logic [127:0]       core_key;
    logic [127:0]       core_out;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [127:0]       rsp_data;
    logic               rsp_id;
    logic [TAGW-1:0]    rsp_tag;
    logic               busy;

    aes_128_sched #(.LAT(LAT), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_state(req_state), .req_key(req_key), .req_tag(req_tag),
        .core_state(core_state), .core_key(core_key), .core_out(core_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_tag(rsp_tag),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in core: known AES vector, otherwise ~(state ^ key), delayed LAT cycles.
    function automatic logic [127:0] fcore(input logic [127:0] s, input logic [127:0] k);
        if (s == P0 && k == K0) return C0;
        return ~(s ^ k);
    endfunction

    logic [127:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= fcore(core_state, core_key);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign core_out = pipe[LAT-1];

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic            id;
        logic [TAGW-1:0] tag;
        logic [127:0]    data;
    } rsp_t;
    rsp_t exp_q[$];
    bit sb_en = 0;

    always @(negedge clk) begin
        if (sb_en) begin
            bit iss;
            rsp_t e;
            iss = 0;
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    e.id   = i[0];
                    e.tag  = req_tag[i*TAGW +: TAGW];
                    e.data = fcore(req_state[i*128 +: 128], req_key[i*128 +: 128]);
                    exp_q.push_back(e);
                    chk("core_state", core_state, req_state[i*128 +: 128]);
                    chk("core_key", core_key, req_key[i*128 +: 128]);
                    iss = 1;
                end
            end
            if (!iss) chk("core_idle", core_state | core_key, 128'h0);
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected: got id=%0d tag=%0d want none", rsp_id, rsp_tag);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_id", rsp_id, e.id);
                    chk("sb_tag", rsp_tag, e.tag);
                    chk("sb_data", rsp_data, e.data);
                end
            end
        end
    end

    task automatic drive(input logic [1:0] v, input logic [127:0] s0, input logic [127:0] s1,
                         input logic [127:0] k0, input logic [127:0] k1,
                         input logic [TAGW-1:0] t0, input logic [TAGW-1:0] t1);
        req_valid = v;
        req_state = {s1, s0};
        req_key   = {k1, k0};
        req_tag   = {t1, t0};
    endtask

    task automatic drain(input string nm);
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_queue"}, exp_q.size(), 0);
    endtask

    typedef struct {
        logic            id;
        logic [127:0]    state;
        logic [127:0]    key;
        logic [TAGW-1:0] tag;
        logic [127:0]    exp;
    } vec_t;
    vec_t vt[4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int t, n, seen;
        bit got, expg, iss;
        logic [127:0] d0;
        logic [TAGW-1:0] tg;

        vt[0] = '{1'b0, P0, K0, 4'h5, C0};
        vt[1] = '{1'b1, {32{4'h1}}, {32{4'h2}}, 4'ha, {32{4'hc}}};
        vt[2] = '{1'b0, {2{64'h0123456789abcdef}}, 128'h0, 4'h3, {2{64'hfedcba9876543210}}};
        vt[3] = '{1'b1, {32{4'hf}}, {16{8'h0f}}, 4'hf, {16{8'h0f}}};

        // Reset: outputs quiet even with both requesters asking.
        rst_n = 0;
        rsp_ready = 1;
        drive(2'b11, P0, {32{4'h1}}, K0, {32{4'h2}}, 4'h5, 4'h6);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_core_state", core_state, 0);
        chk("rst_core_key", core_key, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);

        // First cycle after release: tie goes to requester 0.
        @(posedge clk); #1;
        rst_n = 1;
        sb_en = 1;
        @(negedge clk);
        chk("first_tie", req_ready, 2'b01);
        @(posedge clk); #1;
        req_valid = 0;
        drain("first");

        // Table: single issues, latency and payload.
        for (int v = 0; v < 4; v++) begin
            @(posedge clk); #1;
            if (vt[v].id)
                drive(2'b10, 0, vt[v].state, 0, vt[v].key, 0, vt[v].tag);
            else
                drive(2'b01, vt[v].state, 0, vt[v].key, 0, vt[v].tag, 0);
            got = 0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (req_ready[vt[v].id]) begin
                    got = 1;
                    break;
                end
            end
            chk("vec_issue", got, 1);
            t = cyc;
            @(posedge clk); #1;
            req_valid = 0;
            for (int k = 0; k < LAT + 10; k++) begin
                @(negedge clk);
                if (rsp_valid) break;
            end
            chk("vec_latency", cyc - t, LAT + 1);
            chk("vec_data", rsp_data, vt[v].exp);
            chk("vec_id", rsp_id, vt[v].id);
            chk("vec_tag", rsp_tag, vt[v].tag);
            drain("vec");
        end

        // Round robin with both valid continuously.
        @(posedge clk); #1;
        drive(2'b11, {16{8'ha5}}, {16{8'h5a}}, {16{8'h3c}}, {16{8'hc3}}, 4'h3, 4'h9);
        expg = 0;
        n = 0;
        for (int k = 0; k < 300 && n < 8; k++) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin
                chk("rr_grant", req_ready, expg ? 2'b10 : 2'b01);
                expg = ~expg;
                n++;
            end
        end
        chk("rr_count", n, 8);
        @(posedge clk); #1;
        req_valid = 0;
        drain("rr");

        // Backpressure: exactly DEPTH issues, stable output, credit returns a cycle after pop.
        @(posedge clk); #1;
        rsp_ready = 0;
        tg = 0;
        drive(2'b01, {16{8'h77}}, 0, {16{8'h11}}, 0, tg, 0);
        n = 0;
        for (int k = 0; k < LAT + 20; k++) begin
            @(negedge clk);
            iss = req_ready[0];
            if (iss) n++;
            @(posedge clk); #1;
            if (iss) begin
                tg++;
                req_tag[TAGW-1:0] = tg;
            end
        end
        chk("bp_issues", n, DEPTH);
        @(negedge clk);
        chk("bp_stalled", req_ready, 2'b00);
        chk("bp_rsp_valid", rsp_valid, 1);
        d0 = rsp_data;
        @(negedge clk);
        chk("bp_stable", rsp_data, d0);
        @(posedge clk); #1;
        rsp_ready = 1;
        @(negedge clk);
        chk("bp_pop_cycle_ready", req_ready[0], 0);
        @(negedge clk);
        chk("bp_resume_ready", req_ready[0], 1);
        @(posedge clk); #1;
        req_valid = 0;
        drain("bp");

        // Reset with 3 requests in flight.
        @(posedge clk); #1;
        drive(2'b01, {16{8'h42}}, 0, {16{8'h24}}, 0, 4'h7, 0);
        repeat (3) @(posedge clk);
        #1;
        sb_en = 0;
        rst_n = 0;
        req_valid = 2'b11;
        #1;
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", req_ready, 2'b00);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1;
        req_valid = 0;
        seen = 0;
        for (int k = 0; k < LAT + 2; k++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("mid_rst_no_rsp", seen, 0);
        chk("mid_rst_busy_after", busy, 0);
        sb_en = 1;

        // Issue on the emerge cycle, then push+pop together.
        @(posedge clk); #1;
        rsp_ready = 0;
        tg = 1;
        drive(2'b01, {16{8'h99}}, 0, {16{8'h66}}, 0, tg, 0);
        t = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("em_issue", req_ready[0], 1);
            if (k == 0) t = cyc;
            @(posedge clk); #1;
            tg++;
            req_tag[TAGW-1:0] = tg;
        end
        req_valid = 0;
        while (cyc < t + LAT) begin
            @(posedge clk); #1;
        end
        req_valid = 2'b01;
        @(negedge clk);
        chk("em_issue_on_emerge", req_ready[0], 1);
        @(posedge clk); #1;
        rsp_ready = 1;
        @(negedge clk);
        chk("em_credit_full", req_ready[0], 0);
        chk("em_rsp_valid", rsp_valid, 1);
        @(posedge clk); #1;
        req_valid = 0;
        drain("em");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
